// File: rtl/exmem_block.sv
// exmem_block
//   Execute stage (operand select, ALU, branch/jump resolution) followed by
//   the EX/MEM pipeline register. A taken branch or jump raises PCsel for one
//   cycle, and the instruction behind it is squashed into a bubble.
//
//   Optional feature macro: EXMEM_MUL_EN
//     defined   : ALUControl=15 runs a 32-cycle iterative shift-add multiply
//                 (IDLE/BUSY/DONE FSM). Stall holds the upstream stage.
//     undefined : ALUControl=15 executes as ADD and Stall is tied to 0.
//
//   Ports
//     CLK, RST               clock (rising edge), synchronous active-high reset
//     InPC                   PC of the instruction in IDEX
//     Inrs1_value/Inrs2_value register operands
//     LoadStore32Address     sign-extended load/store/branch offset
//     auipcOrlui             U-type immediate
//     ALUControl             operation code (see OP_* below)
//     ALUSourceA/ALUSourceB  operand selects
//     Inrd, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT
//                            destination and control passed down the pipe
//                            (REB/WEB active-low)
//     ALUOUT, StoreData, JumporBranch, Outrd, OutRegWrite, OutDmemREB,
//     OutDmemWEB, OutDmem1ALUOUT
//                            EX/MEM register outputs
//     PCsel                  one-cycle redirect strobe, target on JumporBranch
//     Stall                  combinational hold request to upstream
module exmem_block (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] InPC,
    input  logic [31:0] Inrs1_value,
    input  logic [31:0] Inrs2_value,
    input  logic [31:0] LoadStore32Address,
    input  logic [31:0] auipcOrlui,
    input  logic [3:0]  ALUControl,
    input  logic [1:0]  ALUSourceA,
    input  logic [2:0]  ALUSourceB,
    input  logic [4:0]  Inrd,
    input  logic        RegWrite,
    input  logic        DmemREB,
    input  logic        DmemWEB,
    input  logic        Dmem1ALUOUT,
    output logic [31:0] ALUOUT,
    output logic [31:0] StoreData,
    output logic [31:0] JumporBranch,
    output logic [4:0]  Outrd,
    output logic        OutRegWrite,
    output logic        OutDmemREB,
    output logic        OutDmemWEB,
    output logic        OutDmem1ALUOUT,
    output logic        PCsel,
    output logic        Stall
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_JAL  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  shamt;
    logic [31:0] aluResult;
    logic [31:0] exResult;
    logic [31:0] target;
    logic        taken;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    always_comb begin
        opA = '0;
        case (ALUSourceA)
            2'd0:    opA = Inrs1_value;
            2'd1:    opA = InPC;
            default: opA = '0;
        endcase
    end

    always_comb begin
        opB = '0;
        case (ALUSourceB)
            3'd0:    opB = Inrs2_value;
            3'd1:    opB = LoadStore32Address;
            3'd2:    opB = auipcOrlui;
            3'd3:    opB = 32'd4;
            default: opB = '0;
        endcase
    end

    assign shamt  = opB[4:0];
    assign target = InPC + LoadStore32Address;

    // ------------------------------------------------------------------
    // ALU and branch resolution. Branch conditions look at the register
    // operands directly, independent of the operand selects, so the selects
    // stay free for the target adder path of the decoder.
    // ------------------------------------------------------------------
    always_comb begin
        aluResult = '0;
        taken     = 1'b0;
        case (ALUControl)
            OP_ADD:  aluResult = opA + opB;
            OP_SUB:  aluResult = opA - opB;
            OP_AND:  aluResult = opA & opB;
            OP_OR:   aluResult = opA | opB;
            OP_XOR:  aluResult = opA ^ opB;
            OP_SLL:  aluResult = opA << shamt;
            OP_SRL:  aluResult = opA >> shamt;
            OP_SRA:  aluResult = $unsigned($signed(opA) >>> shamt);
            OP_SLT:  aluResult = {31'd0, ($signed(opA) < $signed(opB))};
            OP_SLTU: aluResult = {31'd0, (opA < opB)};
            OP_BEQ:  taken = (Inrs1_value == Inrs2_value);
            OP_BNE:  taken = (Inrs1_value != Inrs2_value);
            OP_BLT:  taken = ($signed(Inrs1_value) <  $signed(Inrs2_value));
            OP_BGE:  taken = ($signed(Inrs1_value) >= $signed(Inrs2_value));
            OP_JAL: begin
                aluResult = InPC + 32'd4;
                taken     = 1'b1;
            end
            // Without the multiplier this is plain ADD; with it, the
            // product replaces this value in the DONE cycle.
            OP_MUL:  aluResult = opA + opB;
            default: aluResult = opA + opB;
        endcase
    end

`ifdef EXMEM_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier
    //
    //   state | meaning
    //   ------+----------------------------------------------------------
    //   IDLE  | no multiply in flight; a MUL on a live (non-flushed) slot
    //         | raises Stall and loads the operands
    //   BUSY  | one multiplier bit per cycle, 32 cycles, Stall held high
    //   DONE  | product ready; Stall low so the register captures it
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mulState_t;

    mulState_t   mulState;
    mulState_t   mulNext;
    logic        mulReq;
    logic [5:0]  mulCount;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;

    // A MUL sitting behind a taken branch is wrong-path and is being
    // squashed this cycle, so it must not start the multiplier.
    assign mulReq = (ALUControl == OP_MUL) && !PCsel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mulState <= IDLE;
        end else begin
            mulState <= mulNext;
        end
    end

    always_comb begin
        mulNext = mulState;
        Stall   = 1'b0;
        case (mulState)
            IDLE: begin
                if (mulReq) begin
                    mulNext = BUSY;
                    Stall   = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                // Last bit is processed this cycle; count reaches 0 on entry to DONE.
                if (mulCount == 6'd1) begin
                    mulNext = DONE;
                end
            end
            DONE:    mulNext = IDLE;
            default: mulNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mulCount <= '0;
            mcand    <= '0;
            mplier   <= '0;
            product  <= '0;
        end else if (mulState == IDLE && mulReq) begin
            mulCount <= 6'd32;
            mcand    <= opA;
            mplier   <= opB;
            product  <= '0;
        end else if (mulState == BUSY) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            mulCount <= mulCount - 6'd1;
        end
    end

    assign exResult = (mulState == DONE) ? product : aluResult;
`else
    assign Stall    = 1'b0;
    assign exResult = aluResult;
`endif

    // ------------------------------------------------------------------
    // EX/MEM register. A bubble is captured both when the previous
    // instruction redirected the PC (this slot is wrong-path) and while
    // the multiplier holds the pipe.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALUOUT         <= '0;
            StoreData      <= '0;
            JumporBranch   <= '0;
            Outrd          <= '0;
            OutRegWrite    <= 1'b0;
            OutDmemREB     <= 1'b1;
            OutDmemWEB     <= 1'b1;
            OutDmem1ALUOUT <= 1'b0;
            PCsel          <= 1'b0;
        end else if (PCsel || Stall) begin
            ALUOUT         <= '0;
            StoreData      <= '0;
            JumporBranch   <= '0;
            Outrd          <= '0;
            OutRegWrite    <= 1'b0;
            OutDmemREB     <= 1'b1;
            OutDmemWEB     <= 1'b1;
            OutDmem1ALUOUT <= 1'b0;
            PCsel          <= 1'b0;
        end else begin
            ALUOUT         <= exResult;
            StoreData      <= Inrs2_value;
            JumporBranch   <= target;
            Outrd          <= Inrd;
            OutRegWrite    <= RegWrite;
            OutDmemREB     <= DmemREB;
            OutDmemWEB     <= DmemWEB;
            OutDmem1ALUOUT <= Dmem1ALUOUT;
            PCsel          <= taken;
        end
    end

endmodule
